clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-base and time-setting controller for the 24-hour digital clock. Sits directly upstream of the 6-digit BCD time counter and drives its count-enable and manual-update inputs. It generates a one-cycle 1 Hz tick from the system clock and debounces two push-buttons (mode, increment). A state machine steps through the six digits for manual setting, with an inactivity timeout.

## Interface
- CLK_FREQ_HZ, 50_000_000: clk cycles per second; the tick period.
- DEBOUNCE_CYCLES, 500_000: consecutive stable synchronized cycles needed to accept a button change.
- TIMEOUT_S, 30: seconds without a button press before edit mode is left automatically.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_mode  in  1  raw mode button, active-high, asynchronous and bouncy.
- btn_inc  in  1  raw increment button, active-high, asynchronous and bouncy.
- cnt_en  out  1  one-cycle tick once per second in RUN.
- update_H2  out  1  hours-tens digit selected for editing.
- update_H1  out  1  hours-units digit selected for editing.
- update_M2  out  1  minutes-tens digit selected for editing.
- update_M1  out  1  minutes-units digit selected for editing.
- update_S2  out  1  seconds-tens digit selected for editing.
- update_S1  out  1  seconds-units digit selected for editing.
- update_count  out  1  one-cycle increment pulse for the selected digit.
- edit_active  out  1  high in any SET state.

## Operation
- Each button path:
  - 2-FF synchronizer.
  - Debounce counter runs while the synchronized value differs from the debounced value.
  - The counter clears to 0 whenever the two are equal, so a glitch shorter than DEBOUNCE_CYCLES is discarded.
  - When the count reaches DEBOUNCE_CYCLES, the debounced value takes the synchronized value and the counter clears.
  - Press pulse = debounced rising edge (debounced & ~debounced_d). Releases generate nothing.
- FSM states: RUN, SET_H2, SET_H1, SET_M2, SET_M1, SET_S2, SET_S1.
  - Mode press advances RUN→SET_H2→SET_H1→SET_M2→SET_M1→SET_S2→SET_S1→RUN.
  - Inc press in a SET state: update_count pulses once and the state is unchanged.
  - Inc press in RUN is ignored.
  - Mode press and inc press in the same cycle: mode wins and inc is dropped.
- update_* outputs are registered and one-hot decoded from the state: exactly one high in a SET state, all low in RUN.
  - update_count is only ever high together with exactly one update_* output.
  - Digit wrap-around is handled by the downstream counter, not here.
- Prescaler counts 0..CLK_FREQ_HZ-1 in RUN. cnt_en is high for the one cycle in which the count equals CLK_FREQ_HZ-1, and the count wraps to 0 on that cycle.
  - In SET states the prescaler is held at 0 and cnt_en is low.
  - On return to RUN, the first tick occurs CLK_FREQ_HZ cycles after entry.
- Timeout counter (width $clog2(TIMEOUT_S*CLK_FREQ_HZ+1)):
  - Clears on every press pulse and while in RUN.
  - Increments in SET states.
  - On reaching TIMEOUT_S*CLK_FREQ_HZ, the FSM goes to RUN. This is the same transition as a mode press from SET_S1.
  - A press in the same cycle as the timeout takes precedence: mode advances normally, and inc pulses and clears the timeout.
- Reset values (asserted asynchronously and held while rst_n=0):
  - State RUN; all counters 0.
  - Synchronizers, debounced and delayed values 0.
  - cnt_en, all update_* outputs, update_count and edit_active are 0.
- Reset mid-edit returns the block to RUN immediately, with no update_count pulse.

## Timing
- Raw button held high from the first rising edge that samples it high (edge 1): the press takes effect on edge DEBOUNCE_CYCLES+3.
  - On that edge the state/update_* outputs change (mode), or update_count goes high for one cycle (inc).
- A held button produces exactly one press; there is no auto-repeat.
- A new press requires a debounced release (≥DEBOUNCE_CYCLES low) first.
- cnt_en period in RUN is exactly CLK_FREQ_HZ cycles; its first pulse after reset is at edge CLK_FREQ_HZ.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: CLK_FREQ_HZ=10, DEBOUNCE_CYCLES=4, TIMEOUT_S=3.
- Reset release, no buttons: all outputs 0. cnt_en pulses on edges 10, 20, 30; edit_active stays 0.
- btn_mode bounce (high 2 cycles, low 1, high 3, low): no state change. Then btn_mode held high: on edge 7 of the stable high, update_H2=1 and edit_active=1, and cnt_en stays 0 thereafter.
- Six further clean mode presses: one-hot walks H1, M2, M1, S2, S1, then all low (RUN). cnt_en resumes 10 cycles after RUN entry.
- In SET_M1, three clean inc presses: three single-cycle update_count pulses, each coincident with update_M1=1. Inc pressed in RUN: update_count stays 0.
- Mode and inc presses landing in the same cycle while in SET_H2: state becomes SET_H1, update_count stays 0.
- In SET_S2 with no presses: after 30 cycles, state is RUN and all update_* are 0. Assert rst_n=0 mid-edit in a second run: outputs clear immediately, asynchronously to clk.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// 1 Hz time base plus button-driven digit-setting controller for the 24-hour clock.
// Two debounced buttons step a one-hot digit select and pulse increments downstream.

module clock_set_debounce #(
  parameter int CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  // Any return to the debounced level restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = deb & ~deb_d;
endmodule

module clock_set_ctrl #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TIMEOUT_S       = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_mode,
  input  logic btn_inc,
  output logic cnt_en,
  output logic update_H2,
  output logic update_H1,
  output logic update_M2,
  output logic update_M1,
  output logic update_S2,
  output logic update_S1,
  output logic update_count,
  output logic edit_active
);
  localparam int PRE_W = $clog2(CLK_FREQ_HZ + 1);
  localparam int LIMIT = TIMEOUT_S * CLK_FREQ_HZ;
  localparam int TO_W  = $clog2(LIMIT + 1);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_H2 = 3'd1;
  localparam logic [2:0] SET_H1 = 3'd2;
  localparam logic [2:0] SET_M2 = 3'd3;
  localparam logic [2:0] SET_M1 = 3'd4;
  localparam logic [2:0] SET_S2 = 3'd5;
  localparam logic [2:0] SET_S1 = 3'd6;

  logic             mode_press;
  logic             inc_press;
  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [PRE_W-1:0] pre;
  logic [TO_W-1:0]  tcnt;
  logic             timeout_hit;

  clock_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_mode),
    .press (mode_press)
  );

  clock_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_inc),
    .press (inc_press)
  );

  assign timeout_hit = (tcnt == TO_W'(LIMIT - 1));

  // Any press, mode or inc, holds off the inactivity timeout for that cycle.
  always_comb begin
    next_state = state;
    if (mode_press) begin
      case (state)
        RUN:     next_state = SET_H2;
        SET_H2:  next_state = SET_H1;
        SET_H1:  next_state = SET_M2;
        SET_M2:  next_state = SET_M1;
        SET_M1:  next_state = SET_S2;
        SET_S2:  next_state = SET_S1;
        default: next_state = RUN;
      endcase
    end else if (state != RUN && !inc_press && timeout_hit) begin
      next_state = RUN;
    end
  end

  // Outputs decode next_state so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pre          <= '0;
      tcnt         <= '0;
      cnt_en       <= 1'b0;
      update_H2    <= 1'b0;
      update_H1    <= 1'b0;
      update_M2    <= 1'b0;
      update_M1    <= 1'b0;
      update_S2    <= 1'b0;
      update_S1    <= 1'b0;
      update_count <= 1'b0;
      edit_active  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RUN && next_state == RUN) begin
        if (pre == PRE_W'(CLK_FREQ_HZ - 1)) begin
          pre    <= '0;
          cnt_en <= 1'b1;
        end else begin
          pre    <= pre + PRE_W'(1);
          cnt_en <= 1'b0;
        end
      end else begin
        pre    <= '0;
        cnt_en <= 1'b0;
      end
      if (next_state == RUN || mode_press || inc_press) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TO_W'(1);
      end
      update_H2    <= (next_state == SET_H2);
      update_H1    <= (next_state == SET_H1);
      update_M2    <= (next_state == SET_M2);
      update_M1    <= (next_state == SET_M1);
      update_S2    <= (next_state == SET_S2);
      update_S1    <= (next_state == SET_S1);
      update_count <= inc_press && !mode_press && (next_state != RUN);
      edit_active  <= (next_state != RUN);
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small parameters (10 Hz clock, 4-cycle debounce, 3 s timeout).
// Expected values are hand-derived from the button-to-press latency of 7 edges.

module tb_clock_set_ctrl;
  localparam int CLK_FREQ_HZ     = 10;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int TIMEOUT_S       = 3;

  localparam logic [5:0] SEL_RUN = 6'b000000;
  localparam logic [5:0] SEL_H2  = 6'b100000;
  localparam logic [5:0] SEL_H1  = 6'b010000;
  localparam logic [5:0] SEL_M2  = 6'b001000;
  localparam logic [5:0] SEL_M1  = 6'b000100;
  localparam logic [5:0] SEL_S2  = 6'b000010;
  localparam logic [5:0] SEL_S1  = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic       cnt_en;
  logic       update_H2, update_H1, update_M2, update_M1, update_S2, update_S1;
  logic       update_count;
  logic       edit_active;
  logic [5:0] digit_sel;

  int num_compared   = 0;
  int num_mismatched = 0;

  logic [5:0] walk [6];

  clock_set_ctrl #(
    .CLK_FREQ_HZ     (CLK_FREQ_HZ),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .TIMEOUT_S       (TIMEOUT_S)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cnt_en       (cnt_en),
    .update_H2    (update_H2),
    .update_H1    (update_H1),
    .update_M2    (update_M2),
    .update_M1    (update_M1),
    .update_S2    (update_S2),
    .update_S1    (update_S1),
    .update_count (update_count),
    .edit_active  (edit_active)
  );

  always #5 clk = ~clk;

  assign digit_sel = {update_H2, update_H1, update_M2, update_M1, update_S2, update_S1};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise the chosen buttons and hold them until the press edge (7th edge sampling high).
  task automatic applyStimulus(input logic mode, input logic inc);
    btn_mode = mode;
    btn_inc  = inc;
    repeat (7) step();
  endtask

  task automatic releaseButtons();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (7) step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    walk[0] = SEL_H1;
    walk[1] = SEL_M2;
    walk[2] = SEL_M1;
    walk[3] = SEL_S2;
    walk[4] = SEL_S1;
    walk[5] = SEL_RUN;

    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) step();
    checkOutput("reset cnt_en", cnt_en, 0);
    checkOutput("reset digit_sel", digit_sel, SEL_RUN);
    checkOutput("reset update_count", update_count, 0);
    checkOutput("reset edit_active", edit_active, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] time base after reset");
    for (int k = 1; k <= 30; k++) begin
      step();
      checkOutput($sformatf("cnt_en edge %0d", k), cnt_en, (k % 10 == 0));
      checkOutput($sformatf("edit_active edge %0d", k), edit_active, 0);
    end
    checkOutput("idle digit_sel", digit_sel, SEL_RUN);

    $display("[TB] bouncy mode button");
    btn_mode = 1'b1; repeat (2) step();
    btn_mode = 1'b0; step();
    btn_mode = 1'b1; repeat (3) step();
    btn_mode = 1'b0; repeat (8) step();
    checkOutput("bounce digit_sel", digit_sel, SEL_RUN);
    checkOutput("bounce edit_active", edit_active, 0);

    btn_mode = 1'b1;
    repeat (6) step();
    checkOutput("mode edge 6 digit_sel", digit_sel, SEL_RUN);
    step();
    checkOutput("mode edge 7 digit_sel", digit_sel, SEL_H2);
    checkOutput("mode edge 7 edit_active", edit_active, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput($sformatf("set cnt_en hold %0d", k), cnt_en, 0);
    end
    checkOutput("held no repeat", digit_sel, SEL_H2);
    releaseButtons();

    $display("[TB] mode walk");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("walk %0d digit_sel", i), digit_sel, walk[i]);
      checkOutput($sformatf("walk %0d cnt_en", i), cnt_en, 0);
      releaseButtons();
    end
    checkOutput("walk end edit_active", edit_active, 0);
    repeat (2) step();
    checkOutput("resume edge 9", cnt_en, 0);
    step();
    checkOutput("resume edge 10", cnt_en, 1);
    step();
    checkOutput("resume edge 11", cnt_en, 0);

    $display("[TB] increments in SET_M1");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      releaseButtons();
    end
    checkOutput("reach M1", digit_sel, SEL_M1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("inc %0d pulse", i), update_count, 1);
      checkOutput($sformatf("inc %0d digit_sel", i), digit_sel, SEL_M1);
      step();
      checkOutput($sformatf("inc %0d single cycle", i), update_count, 0);
      releaseButtons();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      releaseButtons();
    end
    checkOutput("back to RUN", digit_sel, SEL_RUN);
    applyStimulus(1'b0, 1'b1);
    checkOutput("inc in RUN pulse", update_count, 0);
    checkOutput("inc in RUN edit_active", edit_active, 0);
    step();
    checkOutput("inc in RUN after", update_count, 0);
    releaseButtons();

    $display("[TB] simultaneous mode and inc");
    applyStimulus(1'b1, 1'b0);
    checkOutput("enter H2", digit_sel, SEL_H2);
    releaseButtons();
    applyStimulus(1'b1, 1'b1);
    checkOutput("both digit_sel", digit_sel, SEL_H1);
    checkOutput("both update_count", update_count, 0);
    step();
    checkOutput("both update_count after", update_count, 0);
    releaseButtons();

    $display("[TB] inactivity timeout");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i < 2) releaseButtons();
    end
    checkOutput("reach S2", digit_sel, SEL_S2);
    releaseButtons();
    repeat (22) step();
    checkOutput("timeout edge 29 digit_sel", digit_sel, SEL_S2);
    step();
    checkOutput("timeout edge 30 digit_sel", digit_sel, SEL_RUN);
    checkOutput("timeout edge 30 edit_active", edit_active, 0);

    $display("[TB] reset mid-edit");
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre-reset digit_sel", digit_sel, SEL_H2);
    releaseButtons();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset digit_sel", digit_sel, SEL_RUN);
    checkOutput("async reset edit_active", edit_active, 0);
    checkOutput("async reset update_count", update_count, 0);
    checkOutput("async reset cnt_en", cnt_en, 0);
    repeat (3) step();
    checkOutput("held reset edit_active", edit_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    checkOutput("after reset digit_sel", digit_sel, SEL_RUN);
    checkOutput("after reset update_count", update_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
